// File: rtl/dcmac_tx_pkg.sv
// Shared widths and arbiter state encoding for the DCMAC tx arbiter.
// State encoding doubles as the one-hot grant vector.
package dcmac_tx_pkg;

    localparam int unsigned NSEG    = 4;
    localparam int unsigned SEG_DW  = 128;
    localparam int unsigned TUSER_W = 5;
    localparam int unsigned DATA_W  = NSEG * SEG_DW;
    localparam int unsigned USER_W  = NSEG * TUSER_W;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/txarb_pkt_counter.sv
// 32-bit packet counter with synchronous clear and increment enable.
// It wraps naturally from 0xFFFFFFFF to 0.
module txarb_pkt_counter (
    input  logic        clk,
    input  logic        i_clr,
    input  logic        i_inc,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/dcmac_tx_arbiter.sv
// Packet-granular round-robin 2:1 arbiter feeding the 4-segment DCMAC tx formatter.
// Define TX_ARB_STATS_EN to add per-source completed-packet counters.
module dcmac_tx_arbiter
    import dcmac_tx_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] i_s0_tdata,
    input  logic [USER_W-1:0] i_s0_tuser,
    input  logic              i_s0_tlast,
    input  logic              i_s0_tvalid,
    output logic              o_s0_tready,
    input  logic [DATA_W-1:0] i_s1_tdata,
    input  logic [USER_W-1:0] i_s1_tuser,
    input  logic              i_s1_tlast,
    input  logic              i_s1_tvalid,
    output logic              o_s1_tready,
    output logic [DATA_W-1:0] o_m_tdata,
    output logic [USER_W-1:0] o_m_tuser,
    output logic              o_m_tlast,
    output logic              o_m_tvalid,
    input  logic              i_m_tready,
`ifdef TX_ARB_STATS_EN
    output logic [31:0]       o_pkt_cnt0,
    output logic [31:0]       o_pkt_cnt1,
`endif
    output logic [1:0]        o_grant
);

    arb_state_e r_state;
    logic       r_rr_ptr;
    logic       w_eop0;
    logic       w_eop1;

    // A packet ends only on an accepted tlast beat from the current owner.
    assign w_eop0 = (r_state == OWN0) && i_s0_tvalid && i_m_tready && i_s0_tlast;
    assign w_eop1 = (r_state == OWN1) && i_s1_tvalid && i_m_tready && i_s1_tlast;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= IDLE;
            r_rr_ptr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_s0_tvalid && i_s1_tvalid) begin
                        r_state  <= r_rr_ptr ? OWN1 : OWN0;
                        r_rr_ptr <= ~r_rr_ptr;
                    end else if (i_s0_tvalid) begin
                        r_state  <= OWN0;
                        r_rr_ptr <= 1'b1;
                    end else if (i_s1_tvalid) begin
                        r_state  <= OWN1;
                        r_rr_ptr <= 1'b0;
                    end
                end
                OWN0: begin
                    if (w_eop0) begin
                        if (i_s1_tvalid) begin
                            r_state  <= OWN1;
                            r_rr_ptr <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                OWN1: begin
                    if (w_eop1) begin
                        if (i_s0_tvalid) begin
                            r_state  <= OWN0;
                            r_rr_ptr <= 1'b1;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant = r_state;

    // Zero-latency mux: the owner's beat passes straight through.
    always_comb begin
        o_m_tdata   = '0;
        o_m_tuser   = '0;
        o_m_tlast   = 1'b0;
        o_m_tvalid  = 1'b0;
        o_s0_tready = 1'b0;
        o_s1_tready = 1'b0;
        case (r_state)
            OWN0: begin
                o_m_tdata   = i_s0_tdata;
                o_m_tuser   = i_s0_tuser;
                o_m_tlast   = i_s0_tlast;
                o_m_tvalid  = i_s0_tvalid;
                o_s0_tready = i_m_tready;
            end
            OWN1: begin
                o_m_tdata   = i_s1_tdata;
                o_m_tuser   = i_s1_tuser;
                o_m_tlast   = i_s1_tlast;
                o_m_tvalid  = i_s1_tvalid;
                o_s1_tready = i_m_tready;
            end
            default: begin
            end
        endcase
    end

`ifdef TX_ARB_STATS_EN
    txarb_pkt_counter u_cnt0 (
        .clk   (clk),
        .i_clr (!resetn),
        .i_inc (w_eop0),
        .o_cnt (o_pkt_cnt0)
    );

    txarb_pkt_counter u_cnt1 (
        .clk   (clk),
        .i_clr (!resetn),
        .i_inc (w_eop1),
        .o_cnt (o_pkt_cnt1)
    );
`endif

endmodule

// File: tb/tb_dcmac_tx_arbiter.sv
// Randomized and directed bench for dcmac_tx_arbiter against a packet-queue reference model.
// Counter checks are active when TX_ARB_STATS_EN is defined.
module tb_dcmac_tx_arbiter;
    import dcmac_tx_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
    logic [USER_W-1:0] s0_tuser, s1_tuser, m_tuser;
    logic              s0_tlast, s1_tlast, m_tlast;
    logic              s0_tvalid, s1_tvalid, m_tvalid;
    logic              s0_tready, s1_tready, m_tready;
    logic [1:0]        grant;
`ifdef TX_ARB_STATS_EN
    logic [31:0]       pkt_cnt0, pkt_cnt1;
`endif

    dcmac_tx_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .i_s0_tdata  (s0_tdata),
        .i_s0_tuser  (s0_tuser),
        .i_s0_tlast  (s0_tlast),
        .i_s0_tvalid (s0_tvalid),
        .o_s0_tready (s0_tready),
        .i_s1_tdata  (s1_tdata),
        .i_s1_tuser  (s1_tuser),
        .i_s1_tlast  (s1_tlast),
        .i_s1_tvalid (s1_tvalid),
        .o_s1_tready (s1_tready),
        .o_m_tdata   (m_tdata),
        .o_m_tuser   (m_tuser),
        .o_m_tlast   (m_tlast),
        .o_m_tvalid  (m_tvalid),
        .i_m_tready  (m_tready),
`ifdef TX_ARB_STATS_EN
        .o_pkt_cnt0  (pkt_cnt0),
        .o_pkt_cnt1  (pkt_cnt1),
`endif
        .o_grant     (grant)
    );

    typedef struct packed {
        logic [DATA_W-1:0] d;
        logic [USER_W-1:0] u;
        logic              l;
    } beat_t;

    // Pending beats per source; the head is what the source presents and what must emerge.
    beat_t       q0[$];
    beat_t       q1[$];
    int          hs_log[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned p_v0, p_v1, p_rdy;
    int          m_owner;   // 0 = nobody, 1 = source 0, 2 = source 1
    int          m_pref;    // source preferred on the next contention
    logic [31:0] m_cnt0, m_cnt1;
    logic [1:0]  obs_grant;
    logic [DATA_W-1:0] held;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t rand_beat(input logic last);
        beat_t b;
        for (int i = 0; i < DATA_W / 32; i++) b.d[i*32 +: 32] = $urandom;
        b.u = USER_W'($urandom);
        b.l = last;
        return b;
    endfunction

    task automatic add_pkt(input int src, input int len);
        for (int i = 0; i < len; i++) begin
            if (src == 0) q0.push_back(rand_beat(i == len - 1));
            else          q1.push_back(rand_beat(i == len - 1));
        end
    endtask

    task automatic drive();
        beat_t g;
        if (q0.size() > 0 && $urandom_range(99) < p_v0) begin
            s0_tvalid = 1'b1; s0_tdata = q0[0].d; s0_tuser = q0[0].u; s0_tlast = q0[0].l;
        end else begin
            g = rand_beat(1'($urandom));
            s0_tvalid = 1'b0; s0_tdata = g.d; s0_tuser = g.u; s0_tlast = g.l;
        end
        if (q1.size() > 0 && $urandom_range(99) < p_v1) begin
            s1_tvalid = 1'b1; s1_tdata = q1[0].d; s1_tuser = q1[0].u; s1_tlast = q1[0].l;
        end else begin
            g = rand_beat(1'($urandom));
            s1_tvalid = 1'b0; s1_tdata = g.d; s1_tuser = g.u; s1_tlast = g.l;
        end
        m_tready = ($urandom_range(99) < p_rdy);
    endtask

    function automatic logic [1:0] owner_grant(input int o);
        return (o == 1) ? 2'b01 : (o == 2) ? 2'b10 : 2'b00;
    endfunction

    // One clock: drive, compare against the model, then advance the model across the edge.
    task automatic step();
        beat_t hb;
        logic  v0, v1, rdy, own_v, eop, other_v;
        @(negedge clk);
        drive();
        #1;
        obs_grant = grant;
        v0 = s0_tvalid; v1 = s1_tvalid; rdy = m_tready; eop = 1'b0;
        check("grant", 512'(grant), 512'(owner_grant(m_owner)));
`ifdef TX_ARB_STATS_EN
        check("pkt_cnt0", 512'(pkt_cnt0), 512'(m_cnt0));
        check("pkt_cnt1", 512'(pkt_cnt1), 512'(m_cnt1));
`endif
        if (m_owner == 0) begin
            check("idle_m_tvalid", 512'(m_tvalid), 512'(0));
            check("idle_s0_tready", 512'(s0_tready), 512'(0));
            check("idle_s1_tready", 512'(s1_tready), 512'(0));
            check("idle_m_tdata", 512'(m_tdata), 512'(0));
            check("idle_m_tuser_tlast", 512'({m_tuser, m_tlast}), 512'(0));
        end else begin
            own_v = (m_owner == 1) ? v0 : v1;
            check("m_tvalid", 512'(m_tvalid), 512'(own_v));
            check("s0_tready", 512'(s0_tready), 512'((m_owner == 1) && rdy));
            check("s1_tready", 512'(s1_tready), 512'((m_owner == 2) && rdy));
            if (own_v) begin
                hb = (m_owner == 1) ? q0[0] : q1[0];
                check("m_tdata", 512'(m_tdata), 512'(hb.d));
                check("m_tuser", 512'(m_tuser), 512'(hb.u));
                check("m_tlast", 512'(m_tlast), 512'(hb.l));
                if (rdy) begin
                    hs_log.push_back(m_owner);
                    if (m_owner == 1) void'(q0.pop_front());
                    else              void'(q1.pop_front());
                    if (hb.l) begin
                        eop = 1'b1;
                        if (m_owner == 1) m_cnt0++;
                        else              m_cnt1++;
                    end
                end
            end
        end
        if (m_owner == 0) begin
            if (v0 && v1)  m_owner = m_pref + 1;
            else if (v0)   m_owner = 1;
            else if (v1)   m_owner = 2;
            if (m_owner != 0) m_pref = (m_owner == 1) ? 1 : 0;
        end else if (eop) begin
            other_v = (m_owner == 1) ? v1 : v0;
            if (other_v) begin
                m_owner = 3 - m_owner;
                m_pref  = (m_owner == 1) ? 1 : 0;
            end else begin
                m_owner = 0;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        drive();
        resetn = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;
        q0.delete(); q1.delete();
        m_owner = 0; m_pref = 0; m_cnt0 = '0; m_cnt1 = '0;
    endtask

    task automatic run_until_idle(input int max);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_owner != 0) && n < max) begin
            step();
            n++;
        end
        check("drain_left", 512'(q0.size() + q1.size()), 512'(0));
    endtask

    initial begin
        logic [15:0] seq;
        resetn = 1'b0;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b0;
        s0_tdata = '0; s1_tdata = '0; s0_tuser = '0; s1_tuser = '0;
        s0_tlast = 1'b0; s1_tlast = 1'b0;
        m_owner = 0; m_pref = 0; m_cnt0 = '0; m_cnt1 = '0;
        p_v0 = 0; p_v1 = 0; p_rdy = 100;

        // Reset state with both sources clamouring
        repeat (2) @(posedge clk);
        @(negedge clk);
        s0_tvalid = 1'b1; s1_tvalid = 1'b1; m_tready = 1'b1;
        #1;
        check("rst_grant", 512'(grant), 512'(0));
        check("rst_m_tvalid", 512'(m_tvalid), 512'(0));
        check("rst_treadys", 512'({s0_tready, s1_tready}), 512'(0));
`ifdef TX_ARB_STATS_EN
        check("rst_cnts", 512'({pkt_cnt0, pkt_cnt1}), 512'(0));
`endif
        @(posedge clk);
        #1;
        resetn = 1'b1;
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;

        // Lone 3-beat s0 packet
        add_pkt(0, 3);
        p_v0 = 100; p_v1 = 0; p_rdy = 100;
        step();
        check("r31_c1_grant", 512'(obs_grant), 512'(2'b00));
        for (int i = 0; i < 3; i++) begin
            step();
            check("r31_beat_grant", 512'(obs_grant), 512'(2'b01));
        end
        step();
        check("r31_back_idle", 512'(obs_grant), 512'(2'b00));
`ifdef TX_ARB_STATS_EN
        check("r31_cnt0", 512'(pkt_cnt0), 512'(1));
`endif

        // Both sources streaming 2-beat packets: strict alternation, no bubble
        p_v0 = 0; p_v1 = 0;
        pulse_reset();
        add_pkt(0, 2); add_pkt(0, 2); add_pkt(1, 2); add_pkt(1, 2);
        p_v0 = 100; p_v1 = 100; p_rdy = 100;
        hs_log.delete();
        repeat (9) step();
        seq = '0;
        foreach (hs_log[i]) seq = {seq[13:0], owner_grant(hs_log[i])};
        check("r32_beats", 512'(hs_log.size()), 512'(8));
        check("r32_order", 512'(seq), 512'(16'b0101_1010_0101_1010));
        run_until_idle(50);

        // Backpressure mid-packet
        p_v0 = 0; p_v1 = 0;
        pulse_reset();
        add_pkt(0, 4); add_pkt(1, 2);
        p_v0 = 100; p_v1 = 100; p_rdy = 100;
        step(); step();
        p_rdy = 0;
        held = q0[0].d;
        repeat (5) begin
            step();
            check("r33_treadys", 512'({s0_tready, s1_tready}), 512'(0));
            check("r33_stable", 512'(m_tdata), 512'(held));
        end
        p_rdy = 100;
        run_until_idle(50);

        // s1 owner goes quiet mid-packet while s0 waits
        p_v0 = 0; p_v1 = 0;
        pulse_reset();
        add_pkt(1, 3); add_pkt(0, 2);
        p_v0 = 0; p_v1 = 100; p_rdy = 100;
        step(); step();
        p_v0 = 100; p_v1 = 0;
        repeat (3) begin
            step();
            check("r34_hold", 512'(obs_grant), 512'(2'b10));
        end
        p_v1 = 100;
        repeat (2) begin
            step();
            check("r34_finish", 512'(obs_grant), 512'(2'b10));
        end
        step();
        check("r34_handover", 512'(obs_grant), 512'(2'b01));
        run_until_idle(50);

        // Reset during beat 2 of a 4-beat s0 packet
        p_v0 = 0; p_v1 = 0;
        pulse_reset();
        add_pkt(0, 4);
        p_v0 = 100; p_rdy = 100;
        step(); step();
        pulse_reset();
        check("r35_grant", 512'(grant), 512'(2'b00));
        check("r35_treadys", 512'({s0_tready, s1_tready, m_tvalid}), 512'(0));
`ifdef TX_ARB_STATS_EN
        check("r35_cnts", 512'({pkt_cnt0, pkt_cnt1}), 512'(0));
`endif
        add_pkt(1, 2);
        p_v1 = 100;
        step();
        check("r35_idle", 512'(obs_grant), 512'(2'b00));
        step();
        check("r35_s1_grant", 512'(obs_grant), 512'(2'b10));
        run_until_idle(50);

`ifdef TX_ARB_STATS_EN
        // Counter wrap
        p_v0 = 0; p_v1 = 0;
        pulse_reset();
        @(negedge clk);
        force dut.u_cnt1.r_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.u_cnt1.r_cnt;
        m_cnt1 = 32'hFFFF_FFFF;
        add_pkt(1, 1);
        p_v1 = 100; p_rdy = 100;
        run_until_idle(20);
        step();
        check("r36_wrap", 512'(pkt_cnt1), 512'(0));
`endif

        // Random traffic with gaps and backpressure
        p_v0 = 0; p_v1 = 0;
        pulse_reset();
        for (int i = 0; i < 30; i++) begin
            add_pkt(0, 1 + $urandom_range(3));
            add_pkt(1, 1 + $urandom_range(3));
        end
        p_v0 = 75; p_v1 = 75; p_rdy = 70;
        run_until_idle(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dcmac_tx_arbiter.md
DCMAC_TX_ARBITER -- requirements
Module: dcmac_tx_arbiter

Interface
REQ-001 Parameter: NSEG, 4, segments per beat (fixed; lane k = bits [128k+127:128k] of tdata, [5k+4:5k] of tuser).
REQ-002 Parameter: SEG_DW, 128, bits per segment.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 s0_tdata / s1_tdata  in  NSEG*SEG_DW  packed beat from source 0 / 1.
REQ-006 s0_tuser / s1_tuser  in  NSEG*5  per lane: bit4 = lane empty, bits3:0 = mty.
REQ-007 s0_tlast / s1_tlast  in  1  last beat of packet.
REQ-008 s0_tvalid / s1_tvalid  in  1  beat valid.
REQ-009 s0_tready / s1_tready  out  1  beat accepted.
REQ-010 m_tdata  out  NSEG*SEG_DW, m_tuser  out  NSEG*5, m_tlast  out  1: granted source's beat.
REQ-011 m_tvalid  out  1, m_tready  in  1: output handshake to the 4-segment DCMAC tx formatter.
REQ-012 grant  out  2  one-hot current owner; 2'b00 when IDLE.
REQ-013 pkt_cnt0 / pkt_cnt1  out  32  completed packets per source (only with TX_ARB_STATS_EN).

Function
REQ-014 Packet-granular 2:1 arbiter; a packet is never interleaved with another.
REQ-015 States: IDLE, OWN0, OWN1; register rr_ptr (1 bit) = preferred source on next contention.
REQ-016 IDLE: m_tvalid=0, s0_tready=s1_tready=0, m_tdata/m_tuser/m_tlast=0.
REQ-017 IDLE -> OWNx next cycle when any s*_tvalid=1; both valid -> x=rr_ptr; single valid -> that source.
REQ-018 OWNx: m_* = sx_* combinationally; sx_tready = m_tready; other source tready=0; zero-latency datapath.
REQ-019 OWNx: sx_tvalid dropping mid-packet holds ownership; m_tvalid follows sx_tvalid.
REQ-020 Leaving OWNx only on sx_tvalid & m_tready & sx_tlast; next state: OWN(other) if other tvalid=1 that cycle, else OWNx if ... never; else IDLE. No same-source back-to-back grant while other is waiting.
REQ-021 Leaving OWNx with no other valid -> IDLE (one-cycle bubble, permitted); a new sx packet re-arbitrates from IDLE.
REQ-022 rr_ptr <= other source whenever a grant to x is taken (IDLE->OWNx or OWNy->OWNx).
REQ-023 Single-beat packet (tlast on first beat) legal; handled identically.
REQ-024 grant reflects state register; never 2'b11.

Reset
REQ-025 resetn=0: state=IDLE, rr_ptr=0 (source 0 preferred), grant=0, all treadys=0, m_tvalid=0, pkt_cnt*=0.
REQ-026 Reset mid-packet abandons the packet; no recovery beat is generated; first post-reset grant follows REQ-017.

Configuration
REQ-027 Macro TX_ARB_STATS_EN defined: pkt_cnt0/pkt_cnt1 present, +1 on each tlast handshake of that source, wrap 0xFFFFFFFF -> 0.
REQ-028 Macro undefined: pkt_cnt ports and counter logic absent; all other behaviour identical.

Structure
REQ-029 Package dcmac_tx_pkg: NSEG, SEG_DW, TUSER_W=5, arbiter state enum (IDLE/OWN0/OWN1).
REQ-030 One sub-module txarb_pkt_counter (32-bit, sync clear, increment enable), instantiated twice under TX_ARB_STATS_EN.

Verification
REQ-031 Only s0 valid, 3-beat packet, m_tready=1 -> cycle1 IDLE, beats out cycles 2-4, grant=01, then IDLE; pkt_cnt0=1.
REQ-032 Both valid from reset, 2-beat packets each continuously -> order s0,s1,s0,s1 with no bubble between packets; grant alternates 01/10.
REQ-033 OWN0 mid-packet, m_tready=0 for 5 cycles -> m_* stable, s0_tready=0, s1_tready=0, no beat lost or duplicated.
REQ-034 OWN1, s1_tvalid low 3 cycles mid-packet while s0 valid -> grant stays 10 until s1 tlast accepted.
REQ-035 resetn pulsed during beat 2 of a 4-beat s0 packet -> next cycle IDLE, grant=00, counters 0; next s1 packet granted normally.
REQ-036 Stats build, preload 0xFFFFFFFF via force, one s1 packet -> pkt_cnt1=0.
